// File: rtl/botao_arbitro.sv
// botao_arbitro: round-robin arbiter for three debounced push-buttons.
// Each press latches a pending flag. A single command at a time goes to the
// game FSM through a valid/ready handshake. After each accepted command there
// is a lockout of COOLDOWN cycles. A press on a button that is already
// pending is dropped and reported.
//
// Ports:
//   clk        system clock (rising edge)
//   rst_n      synchronous active-low reset
//   pulso_in   one-cycle press pulses, bit i = button i
//   cmd_ready  game FSM accepts cmd_id this cycle
//   cmd_valid  cmd_id holds a pending command
//   cmd_id     granted button index 0..2
//   ocupado    high whenever the arbiter is not idle
//   descartado one-cycle pulse when one or more presses were dropped
module botao_arbitro #(
  parameter int unsigned COOLDOWN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] pulso_in,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_id,
  output logic       ocupado,
  output logic       descartado
);

  typedef enum logic [1:0] {OCIOSO, ENVIA, ESPERA} state_t;

  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN);

  state_t     state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic [1:0] id_q, id_d;
  logic       desc_q, desc_d;

  logic       handshake;
  logic [2:0] clear;
  logic [2:0] drop;
  logic [2:0] req;

  // Search starts one past the last accepted index and wraps modulo 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lst);
    logic [1:0] idx;
    logic       found;
    rr_pick = '0;
    found   = 1'b0;
    idx     = (lst == 2'd2) ? 2'd0 : lst + 2'd1;
    for (int unsigned k = 0; k < 3; k++) begin
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    id_d      = id_q;

    handshake = (state_q == ENVIA) && valid_q && cmd_ready;
    clear     = handshake ? (3'b001 << id_q) : 3'b000;
    // A press on the edge its flag is being cleared re-arms it instead of dropping.
    drop      = pulso_in & pending_q & ~clear;
    pending_d = (pending_q & ~clear) | pulso_in;
    desc_d    = |drop;
    req       = pending_q | pulso_in;

    unique case (state_q)
      OCIOSO: begin
        if (|req) begin
          state_d = ENVIA;
          id_d    = rr_pick(req, last_q);
          valid_d = 1'b1;
        end
      end
      ENVIA: begin
        if (handshake) begin
          last_d  = id_q;
          valid_d = 1'b0;
          cnt_d   = CD_LOAD;
          state_d = ESPERA;
        end
      end
      ESPERA: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      pending_q <= '0;
      last_q    <= 2'd2;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      desc_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      desc_q    <= desc_d;
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd_id     = id_q;
  assign ocupado    = (state_q != OCIOSO);
  assign descartado = desc_q;

endmodule

// File: tb/tb_botao_arbitro.sv
// Testbench for botao_arbitro: two instances (COOLDOWN=4 and COOLDOWN=1)
// share the input stimulus. Each cycle's expected outputs are pushed to a
// scoreboard queue when the inputs are driven, and popped and compared
// just after the following rising edge.
module tb_botao_arbitro;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pulso_in;
  logic       cmd_ready;

  logic       va, oa, da;
  logic [1:0] ida;
  logic       vb, ob, db;
  logic [1:0] idb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  botao_arbitro #(.COOLDOWN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .pulso_in(pulso_in), .cmd_ready(cmd_ready),
    .cmd_valid(va), .cmd_id(ida), .ocupado(oa), .descartado(da)
  );

  botao_arbitro #(.COOLDOWN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pulso_in(pulso_in), .cmd_ready(cmd_ready),
    .cmd_valid(vb), .cmd_id(idb), .ocupado(ob), .descartado(db)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] pulso;
    logic       ready;
    logic       v;
    logic [1:0] id;
    logic       ocu;
    logic       desc;
  } vec_t;

  typedef struct {
    bit         which;
    int         step;
    logic       v;
    logic [1:0] id;
    logic       chk_id;
    logic       ocu;
    logic       desc;
  } exp_t;

  vec_t vec_a[$];
  vec_t vec_b[$];
  exp_t sb[$];
  int   step_no = 0;

  function automatic vec_t mk(logic r, logic [2:0] p, logic rd,
                              logic v, logic [1:0] id, logic o, logic d);
    vec_t x;
    x.rst_n = r; x.pulso = p; x.ready = rd;
    x.v = v; x.id = id; x.ocu = o; x.desc = d;
    return x;
  endfunction

  task automatic check(input string name, input int step, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, req);
    end
  endtask

  // Drive one cycle, record expectations, compare after the edge.
  task automatic apply(input bit which, input vec_t x);
    exp_t e;
    rst_n     = x.rst_n;
    pulso_in  = x.pulso;
    cmd_ready = x.ready;
    e.which = which; e.step = step_no;
    e.v = x.v; e.id = x.id; e.ocu = x.ocu; e.desc = x.desc;
    e.chk_id = x.v | ~x.rst_n;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty step %0d", step_no);
    end else begin
      e = sb.pop_front();
      if (e.which == 1'b0) begin
        check("a_cmd_valid", e.step, int'(va), int'(e.v));
        if (e.chk_id) check("a_cmd_id", e.step, int'(ida), int'(e.id));
        check("a_ocupado", e.step, int'(oa), int'(e.ocu));
        check("a_descartado", e.step, int'(da), int'(e.desc));
      end else begin
        check("b_cmd_valid", e.step, int'(vb), int'(e.v));
        if (e.chk_id) check("b_cmd_id", e.step, int'(idb), int'(e.id));
        check("b_ocupado", e.step, int'(ob), int'(e.ocu));
        check("b_descartado", e.step, int'(db), int'(e.desc));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pulso_in = '0; cmd_ready = 1'b0;

    // COOLDOWN=4: rst, p, rdy | v, id, ocu, desc
    // reset and single press
    vec_a.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b010, 1, 1, 1, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 1, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0));
    // backpressure, duplicate press dropped, later press does not change id
    vec_a.push_back(mk(1, 3'b001, 0, 1, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b001, 0, 1, 0, 1, 1));
    vec_a.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b100, 0, 1, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0));
    // pending button 2 served; re-press on its accept edge
    vec_a.push_back(mk(1, 3'b000, 0, 1, 2, 1, 0));
    vec_a.push_back(mk(1, 3'b100, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 1, 2, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0));
    // reset mid-ENVIA with pending 101
    vec_a.push_back(mk(1, 3'b101, 0, 1, 0, 1, 0));
    vec_a.push_back(mk(0, 3'b010, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b100, 0, 1, 2, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    // two-button drop gives one descartado pulse; ready ignored in ESPERA
    vec_a.push_back(mk(1, 3'b011, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b011, 1, 0, 0, 1, 1));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_a.push_back(mk(1, 3'b000, 0, 1, 0, 1, 0));
    vec_a.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));

    // COOLDOWN=1 fairness: all three pressed together, ready held high
    vec_b.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 3'b111, 1, 1, 0, 1, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 1, 1, 1, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 1, 2, 1, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 1, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));
    vec_b.push_back(mk(1, 3'b000, 1, 0, 0, 0, 0));

    @(negedge clk);
    for (int i = 0; i < vec_a.size(); i++) apply(1'b0, vec_a[i]);

    // Hand sequence: reset during ESPERA with button 1 still pending;
    // the stale flag must be gone and a fresh press restarts at index order 0,1,2.
    apply(1'b0, mk(0, 3'b000, 0, 0, 0, 0, 0));
    apply(1'b0, mk(1, 3'b000, 0, 0, 0, 0, 0));
    apply(1'b0, mk(1, 3'b110, 0, 1, 1, 1, 0));
    apply(1'b0, mk(1, 3'b000, 1, 0, 0, 1, 0));
    apply(1'b0, mk(1, 3'b000, 0, 0, 0, 1, 0));
    apply(1'b0, mk(1, 3'b000, 0, 0, 0, 1, 0));
    apply(1'b0, mk(1, 3'b000, 0, 0, 0, 1, 0));
    apply(1'b0, mk(1, 3'b000, 0, 0, 0, 0, 0));
    apply(1'b0, mk(1, 3'b000, 0, 1, 2, 1, 0));

    for (int i = 0; i < vec_b.size(); i++) apply(1'b1, vec_b[i]);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/botao_arbitro.md
BOTAO_ARBITRO -- requirements
Module: botao_arbitro

Interface
REQ-001 Parameter COOLDOWN, default 255, SHALL set the lockout length in clk cycles after each accepted command; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 pulso_in  input  3  SHALL carry one-cycle debounced press pulses, bit i = button i.
REQ-005 cmd_ready  input  1  SHALL mean the game FSM accepts cmd_id this cycle.
REQ-006 cmd_valid  output  1  SHALL mean cmd_id holds a pending command.
REQ-007 cmd_id  output  2  SHALL give the granted button index, 0..2.
REQ-008 ocupado  output  1  SHALL be high whenever the FSM is not in OCIOSO.
REQ-009 descartado  output  1  SHALL pulse high for one cycle when a press is dropped.

Function
REQ-010 Each button SHALL have one pending flag; pulso_in[i]=1 at an edge sets pending[i], in every state including ESPERA.
REQ-011 A pulse on a button whose pending flag is already set and not being cleared that edge SHALL be dropped, with descartado=1 for the next cycle.
REQ-012 A pulse arriving on the same edge its pending flag is cleared by acceptance SHALL set the flag again and SHALL NOT be dropped.
REQ-013 Drops on several buttons at one edge SHALL produce a single one-cycle descartado pulse.
REQ-014 The FSM SHALL have three states: OCIOSO, ENVIA, ESPERA.
REQ-015 OCIOSO: if (pending | pulso_in) is nonzero at an edge, the FSM SHALL go to ENVIA, register cmd_id as the round-robin winner and set cmd_valid=1.
REQ-016 Latency: a pulse sampled at edge k in OCIOSO with no other requests SHALL give cmd_valid=1 and the matching cmd_id from edge k.
REQ-017 Round-robin: the search SHALL start at index (last+1) mod 3, where last is the most recently accepted index; last=2 after reset, so the priority order is 0,1,2.
REQ-018 ENVIA: cmd_valid and cmd_id SHALL stay stable until an edge with cmd_ready=1; later pulses SHALL NOT change cmd_id.
REQ-019 On an edge with cmd_valid=1 and cmd_ready=1, the block SHALL:
 - clear pending[cmd_id];
 - set last=cmd_id;
 - clear cmd_valid;
 - load the cooldown counter with COOLDOWN;
 - go to ESPERA.
REQ-020 ESPERA: the counter SHALL decrement each edge; on the edge where it reads 1 the FSM SHALL go to OCIOSO, so ESPERA lasts exactly COOLDOWN cycles.
REQ-021 cmd_ready SHALL be ignored while cmd_valid=0.
REQ-022 The counter SHALL be 8 bits and SHALL NOT wrap: it is only loaded in ENVIA and only decremented in ESPERA.
REQ-023 Simultaneous pulses on several buttons SHALL all be latched and served one per handshake, in round-robin order.

Reset
REQ-024 rst_n=0 at an edge SHALL clear every pending flag and the counter, set last=2, set state=OCIOSO, and clear cmd_valid, cmd_id, ocupado and descartado, in any state.
REQ-025 pulso_in and cmd_ready SHALL be ignored on any edge where rst_n=0; reset during ENVIA SHALL discard the offered command with no handshake.

Verification
REQ-026 Single press: COOLDOWN=4, pulso_in=3'b010 at edge k, cmd_ready=1 -> cmd_valid=1 and cmd_id=1 from edge k, accepted at edge k+1, ocupado=1 for 4 ESPERA cycles, then ocupado=0.
REQ-027 Fairness: pulso_in=3'b111 at one edge, cmd_ready held 1, COOLDOWN=1 -> cmd_id sequence 0,1,2, with descartado never set.
REQ-028 Backpressure and drop: cmd_ready=0, a pulse on button 0 then a second pulse on button 0 -> cmd_id=0 held stable, and descartado=1 for exactly one cycle after the second pulse.
REQ-029 Re-press on accept edge: a pulse on button 2 on the same edge as its acceptance -> no drop, and button 2 is served again after cooldown.
REQ-030 Reset mid-ENVIA: rst_n=0 with cmd_valid=1 and pending=3'b101 -> next cycle all outputs 0 and pending=0; after release the first pulse on button 2 is served with cmd_id=2.
